// File: rtl/vga_fb_writer.sv
// Write side of the 1-bpp SRAM framebuffer: single-pixel read-modify-write
// and whole-frame clear through the shared word-wide SRAM port.
module vga_fb_writer #(
  parameter int          FB_WIDTH  = 128,
  parameter int          FB_HEIGHT = 96,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_x,
  input  logic [6:0]  req_y,
  output logic        done,
  output logic        err,
  input  logic        SRAM_busy,
  input  logic [31:0] SRAM_data_in,
  output logic [31:0] SRAM_data_out,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        read_en,
  output logic        write_en,
  output logic [2:0]  dbg_state
);

  localparam int WORDS_PER_ROW = FB_WIDTH / 32;
  localparam int FB_WORDS      = WORDS_PER_ROW * FB_HEIGHT;
  localparam int CNT_W         = $clog2(FB_WORDS);

  localparam logic [1:0] OP_CLR_PIX   = 2'b00;
  localparam logic [1:0] OP_SET_PIX   = 2'b01;
  localparam logic [1:0] OP_TGL_PIX   = 2'b10;
  localparam logic [1:0] OP_CLR_FRAME = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MOD  = 3'd2,
    S_WR   = 3'd3,
    S_CLR  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic [4:0]         r_bit;
  logic [31:0]        r_addr;
  logic [31:0]        r_word;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_err;

  logic               w_reject;
  logic               w_last;
  logic [31:0]        w_req_addr;
  logic [31:0]        w_mask;

  assign w_reject   = {25'd0, req_y} >= 32'(FB_HEIGHT);
  assign w_last     = r_cnt == CNT_W'(FB_WORDS - 1);
  assign w_req_addr = BASE_ADDR + 32'(req_y) * 32'(WORDS_PER_ROW) + 32'(req_x >> 5);
  assign w_mask     = 32'd1 << r_bit;

  // Valid/ready: a command transfers at a posedge where req_valid && req_ready.
  // req_ready is high only in IDLE, which includes the cycle done is pulsed.
  always_comb begin
    w_next            = r_state;
    req_ready         = 1'b0;
    read_en           = 1'b0;
    write_en          = 1'b0;
    word_address_dest = 32'd0;
    SRAM_data_out     = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_CLR_FRAME) w_next = S_CLR;
          else if (!w_reject)         w_next = S_RD;
        end
      end
      S_RD: begin
        read_en           = 1'b1;
        word_address_dest = r_addr;
        if (!SRAM_busy) w_next = S_MOD;
      end
      S_MOD: w_next = S_WR;
      S_WR: begin
        write_en          = 1'b1;
        word_address_dest = r_addr;
        SRAM_data_out     = r_word;
        if (!SRAM_busy) w_next = S_IDLE;
      end
      S_CLR: begin
        write_en          = 1'b1;
        word_address_dest = BASE_ADDR + 32'(r_cnt);
        if (!SRAM_busy && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    byte_select = (read_en || write_en) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_bit   <= 5'd0;
      r_addr  <= 32'd0;
      r_word  <= 32'd0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_bit  <= req_x[4:0];
            r_addr <= w_req_addr;
            r_cnt  <= '0;
            if (req_op != OP_CLR_FRAME && w_reject) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        S_RD: if (!SRAM_busy) r_word <= SRAM_data_in;
        S_MOD: begin
          case (r_op)
            OP_CLR_PIX: r_word <= r_word & ~w_mask;
            OP_SET_PIX: r_word <= r_word | w_mask;
            OP_TGL_PIX: r_word <= r_word ^ w_mask;
            default:    r_word <= r_word;
          endcase
        end
        S_WR: if (!SRAM_busy) r_done <= 1'b1;
        S_CLR: begin
          // The counter parks on the last word rather than wrapping.
          if (!SRAM_busy) begin
            if (w_last) r_done <= 1'b1;
            else        r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer with a behavioural SRAM and immediate
// assertions at each check point.
module tb_vga_fb_writer;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_x;
  logic [6:0]  req_y;
  logic        done;
  logic        err;
  logic        SRAM_busy;
  logic [31:0] SRAM_data_in;
  logic [31:0] SRAM_data_out;
  logic [31:0] word_address_dest;
  logic [3:0]  byte_select;
  logic        read_en;
  logic        write_en;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [512];
  logic        pre_en;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;
  logic        fill_en;
  logic [31:0] fill_data;
  logic [31:0] exp_q[$];

  vga_fb_writer dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .done(done), .err(err),
    .SRAM_busy(SRAM_busy), .SRAM_data_in(SRAM_data_in),
    .SRAM_data_out(SRAM_data_out), .word_address_dest(word_address_dest),
    .byte_select(byte_select), .read_en(read_en), .write_en(write_en),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: transfer completes on a posedge with enable high and busy low
  assign SRAM_data_in = mem[word_address_dest[8:0]];
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 512; i++) mem[i] <= fill_data;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (write_en && !SRAM_busy) begin
      mem[word_address_dest[8:0]] <= SRAM_data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic fill(input logic [31:0] d);
    fill_en = 1'b1; fill_data = d;
    tick();
    fill_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] x, input logic [6:0] y);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [6:0] x,
                         input logic [6:0] y);
    int n;
    issue(op, x, y);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    tick();
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_x = 7'd0; req_y = 7'd0;
    SRAM_busy = 1'b0; pre_en = 1'b0; pre_addr = 9'd0; pre_data = 32'd0;
    fill_en = 1'b0; fill_data = 32'd0;
    #1;
    // reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_rd",    {31'd0, read_en}, 32'd0);
    chk("rst_wr",    {31'd0, write_en}, 32'd0);
    chk("rst_addr",  word_address_dest, 32'd0);
    chk("rst_data",  SRAM_data_out, 32'd0);
    chk("rst_bs",    {28'd0, byte_select}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    fill(32'd0);

    // reset mid-WR: set x=70,y=12 -> word 50, stall in WR, then reset
    preload(9'd50, 32'h1234_0000);
    issue(2'b01, 7'd70, 7'd12);
    chk("t1_rd_addr", word_address_dest, 32'd50);
    tick();
    SRAM_busy = 1'b1;
    tick();
    chk("t1_in_wr", {31'd0, write_en}, 32'd1);
    tick();
    nrst = 1'b0;
    #1;
    chk("t1_wr_drop", {31'd0, write_en}, 32'd0);
    chk("t1_ready",   {31'd0, req_ready}, 32'd1);
    chk("t1_done",    {31'd0, done}, 32'd0);
    tick();
    chk("t1_mem", mem[50], 32'h1234_0000);
    nrst = 1'b1;
    SRAM_busy = 1'b0;
    tick();

    // set x=37,y=2 on zero word 9, no stall
    preload(9'd9, 32'd0);
    issue(2'b01, 7'd37, 7'd2);
    chk("t2_rd",      {31'd0, read_en}, 32'd1);
    chk("t2_rd_addr", word_address_dest, 32'd9);
    chk("t2_bs",      {28'd0, byte_select}, 32'hF);
    chk("t2_busy_rdy",{31'd0, req_ready}, 32'd0);
    tick();
    chk("t2_mod_rd",  {31'd0, read_en}, 32'd0);
    chk("t2_mod_wr",  {31'd0, write_en}, 32'd0);
    tick();
    chk("t2_wr",      {31'd0, write_en}, 32'd1);
    chk("t2_wr_addr", word_address_dest, 32'd9);
    chk("t2_wr_data", SRAM_data_out, 32'h0000_0020);
    tick();
    chk("t2_done",    {31'd0, done}, 32'd1);
    chk("t2_err",     {31'd0, err}, 32'd0);
    chk("t2_mem",     mem[9], 32'h0000_0020);
    tick();
    chk("t2_done_end",{31'd0, done}, 32'd0);

    // toggle x=0,y=95 on all-ones word 380 with 5-cycle stalls
    preload(9'd380, 32'hFFFF_FFFF);
    SRAM_busy = 1'b1;
    issue(2'b10, 7'd0, 7'd95);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rd_hold", {31'd0, read_en}, 32'd1);
      chk("t3_rd_addr", word_address_dest, 32'd380);
      tick();
    end
    SRAM_busy = 1'b0;
    tick();
    chk("t3_mod", {30'd0, read_en, write_en}, 32'd0);
    SRAM_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_wr_hold", {31'd0, write_en}, 32'd1);
      chk("t3_wr_addr", word_address_dest, 32'd380);
      chk("t3_wr_data", SRAM_data_out, 32'hFFFF_FFFE);
      chk("t3_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    SRAM_busy = 1'b0;
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_mem",  mem[380], 32'hFFFF_FFFE);
    tick();

    // out-of-range row is rejected without SRAM traffic
    issue(2'b01, 7'd5, 7'd96);
    chk("t4_done",  {31'd0, done}, 32'd1);
    chk("t4_err",   {31'd0, err}, 32'd1);
    chk("t4_noacc", {30'd0, read_en, write_en}, 32'd0);
    chk("t4_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("t4_pulse", {30'd0, done, err}, 32'd0);
    issue(2'b10, 7'd127, 7'd127);
    chk("t4b_err",  {30'd0, done, err}, 32'd3);
    tick();

    // clear frame on all-ones memory
    fill(32'hFFFF_FFFF);
    for (int i = 0; i < 384; i++) exp_q.push_back(32'(i));
    issue(2'b11, 7'd9, 7'd9);
    for (int i = 0; i < 384; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk("t5_wr",   {31'd0, write_en}, 32'd1);
      chk("t5_addr", word_address_dest, e);
      chk("t5_data", SRAM_data_out, 32'd0);
      chk("t5_done_early", {30'd0, read_en, done}, 32'd0);
      tick();
    end
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_idle", {30'd0, read_en, write_en}, 32'd0);
    tick();
    chk("t5_single", {31'd0, done}, 32'd0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 384; i++) if (mem[i] !== 32'd0) nz++;
      chk("t5_zeroed", 32'(nz), 32'd0);
    end
    chk("t5_beyond", mem[384], 32'hFFFF_FFFF);
    run_cmd("t5_set127", 2'b01, 7'd127, 7'd0);
    chk("t5_mem3", mem[3], 32'h8000_0000);

    // back-to-back: valid held, fields changed right after accept
    req_valid = 1'b1; req_op = 2'b01; req_x = 7'd1; req_y = 7'd10;
    tick();
    req_x = 7'd33;
    chk("t6_a_addr", word_address_dest, 32'd40);
    tick();
    tick();
    chk("t6_a_data", SRAM_data_out, 32'h0000_0002);
    tick();
    chk("t6_a_done",  {31'd0, done}, 32'd1);
    chk("t6_a_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t6_b_rd",   {31'd0, read_en}, 32'd1);
    chk("t6_b_addr", word_address_dest, 32'd41);
    chk("t6_b_nd",   {31'd0, done}, 32'd0);
    tick();
    tick();
    tick();
    chk("t6_b_done", {31'd0, done}, 32'd1);
    chk("t6_mem40",  mem[40], 32'h0000_0002);
    chk("t6_mem41",  mem[41], 32'h0000_0002);
    tick();

    // clear-pixel and toggle back to zero
    run_cmd("t7_clr", 2'b00, 7'd37, 7'd2);
    chk("t7_mem9", mem[9], 32'd0);
    run_cmd("t7_tgl", 2'b10, 7'd33, 7'd10);
    chk("t7_mem41", mem[41], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
